phase_sequencer: RTL and testbench
==================================

PHASE_SEQUENCER -- requirements
Module: phase_sequencer

Interface
REQ-001 Parameter COUNTER_BITS, default 32: width of every duration and limit value.
REQ-002 Parameter NUM_PHASES, default 4: number of timed phases per pass, at least 2.
REQ-003 i_CLK  in  1  single clock; all state changes on rising edge.
REQ-004 i_RST  in  1  reset, asynchronous, active-high.
REQ-005 i_START  in  1  level-sampled start request; honoured only in IDLE.
REQ-006 i_ABORT  in  1  synchronous abort; returns to IDLE from any state.
REQ-007 i_DUR  in  NUM_PHASES*COUNTER_BITS  packed phase durations; phase p occupies bits [p*COUNTER_BITS +: COUNTER_BITS].
REQ-008 i_OVERFLOW  in  1  overflow level from the downstream limit counter.
REQ-009 o_LIM  out  COUNTER_BITS  limit for the downstream counter; equals the current phase's latched duration.
REQ-010 o_CNT_RST  out  1  registered one-cycle pulse that restarts the downstream counter.
REQ-011 o_PHASE  out  clog2(NUM_PHASES)  current phase index.
REQ-012 o_BUSY  out  1  high in every state except IDLE.
REQ-013 o_DONE  out  1  registered one-cycle pulse at end of pass.

Function
REQ-014 States SHALL be IDLE, ARM, WAIT, ADVANCE, DONE.
REQ-015 IDLE with i_START=1 at an edge SHALL latch all of i_DUR, set o_PHASE=0, and enter ARM.
REQ-016 ARM SHALL assert o_CNT_RST for exactly one cycle and drive o_LIM with the current duration. Next state is WAIT, or ADVANCE if that duration is 0 (a zero phase is skipped with no counter restart).
REQ-017 WAIT SHALL hold until i_OVERFLOW=1 is sampled, then enter ADVANCE.
REQ-018 ADVANCE SHALL take one cycle. If o_PHASE < NUM_PHASES-1: increment o_PHASE and enter ARM. Otherwise: enter DONE.
REQ-019 DONE SHALL assert o_DONE for one cycle, then enter IDLE. o_PHASE holds its last value until the next start.
REQ-020 Latched durations SHALL be immune to i_DUR changes until the next accepted start.
REQ-021 i_START outside IDLE SHALL be ignored.
REQ-022 i_ABORT=1 SHALL enter IDLE at the next edge, pulse o_CNT_RST once (unless already in IDLE), and suppress o_DONE.
REQ-023 i_ABORT and i_START high together: i_ABORT wins.
REQ-024 i_OVERFLOW SHALL be ignored outside WAIT.

Reset
REQ-025 i_RST=1 SHALL immediately force IDLE, with o_PHASE=0, o_LIM=0, o_CNT_RST=0, o_BUSY=0, o_DONE=0, and all latched durations 0, regardless of clock.
REQ-026 Reset mid-pass SHALL discard the pass; no o_DONE is produced.

Configuration
REQ-027 Macro PHASE_SEQ_LOOP_EN defined: ADVANCE from the last phase SHALL wrap o_PHASE to 0 and enter ARM, with no DONE state and no o_DONE pulse; the sequence runs until i_ABORT or i_RST. Durations are not re-latched on wrap.
REQ-028 Macro PHASE_SEQ_LOOP_EN undefined: single pass per REQ-018/019.

Structure
REQ-029 Package phase_seq_pkg SHALL hold the state enumeration, the default NUM_PHASES, and the phase-index width function.
REQ-030 Sub-module phase_dur_bank SHALL hold the duration capture registers and the phase-indexed output mux that feeds o_LIM.

Verification
The bench uses a behavioural limit counter: it clears on o_CNT_RST and asserts overflow when the count reaches o_LIM.
REQ-031 i_DUR={3,5,2,4}, i_START for one cycle -> o_PHASE steps 0,1,2,3; 4 o_CNT_RST pulses; each WAIT exits exactly one edge after overflow; one o_DONE pulse; o_BUSY=0 afterward.
REQ-032 i_DUR={3,0,2,4} -> phase 1 is skipped in ARM->ADVANCE; 3 o_CNT_RST pulses total; o_DONE is asserted once.
REQ-033 i_ABORT asserted during WAIT of phase 2 -> IDLE at the next edge; one o_CNT_RST pulse; no o_DONE; o_BUSY=0.
REQ-034 i_RST asserted between clock edges during WAIT -> all outputs reach reset values before the next edge; i_START afterward begins at phase 0.
REQ-035 i_START and i_ABORT both high in IDLE -> remains IDLE. i_DUR rewritten to all 1 during phase 1 -> remaining phases still use the original values.
REQ-036 PHASE_SEQ_LOOP_EN defined, i_DUR={2,2,2,2} -> sequence 0,1,2,3,0,1,... with no o_DONE over 3 passes; i_ABORT then returns to IDLE.

Source files
------------

// File: rtl/phase_seq_pkg.sv
// Shared definitions for the phase sequencer: the state enumeration,
// default sizing and the helper that sizes the phase index.
// Optional feature macro: PHASE_SEQ_LOOP_EN (continuous looping mode).
package phase_seq_pkg;

    localparam int DEFAULT_NUM_PHASES   = 4;
    localparam int DEFAULT_COUNTER_BITS = 32;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARM     = 3'd1,
        WAIT    = 3'd2,
        ADVANCE = 3'd3,
        DONE    = 3'd4
    } seqState_t;

    // Width of a phase index; never less than one bit.
    function automatic int phaseWidth(input int numPhases);
        return (numPhases > 1) ? $clog2(numPhases) : 1;
    endfunction

endpackage

// File: rtl/phase_dur_bank.sv
// Duration bank: captures every phase duration when a pass starts and
// offers two phase-indexed read ports. The current port feeds o_LIM; the
// peek port looks at the phase about to be armed, and sees the incoming
// i_DUR directly on the load cycle so the first phase can be judged
// before the capture registers have updated.
module phase_dur_bank
    import phase_seq_pkg::*;
#(
    parameter int COUNTER_BITS = DEFAULT_COUNTER_BITS,
    parameter int NUM_PHASES   = DEFAULT_NUM_PHASES
) (
    input  logic                                 i_CLK,
    input  logic                                 i_RST,
    input  logic                                 i_LOAD,
    input  logic [NUM_PHASES*COUNTER_BITS-1:0]   i_DUR,
    input  logic [phaseWidth(NUM_PHASES)-1:0]    i_CUR_SEL,
    input  logic [phaseWidth(NUM_PHASES)-1:0]    i_PEEK_SEL,
    output logic [COUNTER_BITS-1:0]              o_CUR_DUR,
    output logic [COUNTER_BITS-1:0]              o_PEEK_DUR
);

    localparam int PW = phaseWidth(NUM_PHASES);

    logic [COUNTER_BITS-1:0] r_dur [NUM_PHASES];

    // Capture all durations together on an accepted start; hold otherwise.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            for (int p = 0; p < NUM_PHASES; p++) begin
                r_dur[p] <= '0;
            end
        end else if (i_LOAD) begin
            for (int p = 0; p < NUM_PHASES; p++) begin
                r_dur[p] <= i_DUR[p*COUNTER_BITS +: COUNTER_BITS];
            end
        end
    end

    // Current-phase mux driving the downstream limit.
    always_comb begin
        o_CUR_DUR = '0;
        for (int p = 0; p < NUM_PHASES; p++) begin
            if (i_CUR_SEL == PW'(p)) begin
                o_CUR_DUR = r_dur[p];
            end
        end
    end

    // Look-ahead mux for the phase being armed next, bypassing on load.
    always_comb begin
        o_PEEK_DUR = '0;
        for (int p = 0; p < NUM_PHASES; p++) begin
            if (i_PEEK_SEL == PW'(p)) begin
                o_PEEK_DUR = i_LOAD ? i_DUR[p*COUNTER_BITS +: COUNTER_BITS] : r_dur[p];
            end
        end
    end

endmodule

// File: rtl/phase_sequencer.sv
// Phase sequencer: steps through NUM_PHASES timed phases, restarting an
// external limit counter for each non-zero phase and advancing when that
// counter reports overflow. A pass ends with a one-cycle o_DONE pulse.
// Optional feature macro: PHASE_SEQ_LOOP_EN -- when defined the last phase
// wraps back to phase 0 with no DONE state, running until abort or reset.
module phase_sequencer
    import phase_seq_pkg::*;
#(
    parameter int COUNTER_BITS = DEFAULT_COUNTER_BITS,
    parameter int NUM_PHASES   = DEFAULT_NUM_PHASES
) (
    input  logic                                 i_CLK,
    input  logic                                 i_RST,
    input  logic                                 i_START,
    input  logic                                 i_ABORT,
    input  logic [NUM_PHASES*COUNTER_BITS-1:0]   i_DUR,
    input  logic                                 i_OVERFLOW,
    output logic [COUNTER_BITS-1:0]              o_LIM,
    output logic                                 o_CNT_RST,
    output logic [phaseWidth(NUM_PHASES)-1:0]    o_PHASE,
    output logic                                 o_BUSY,
    output logic                                 o_DONE
);

    localparam int            PW         = phaseWidth(NUM_PHASES);
    localparam logic [PW-1:0] LAST_PHASE = PW'(NUM_PHASES - 1);

    seqState_t               r_state;
    seqState_t               w_nextState;
    logic [PW-1:0]           r_phase;
    logic [PW-1:0]           w_nextPhase;
    logic                    w_load;
    logic                    r_cntRst;
    logic                    r_done;
    logic                    w_cntRstNext;
    logic                    w_doneNext;
    logic [COUNTER_BITS-1:0] w_curDur;
    logic [COUNTER_BITS-1:0] w_peekDur;

    phase_dur_bank #(
        .COUNTER_BITS (COUNTER_BITS),
        .NUM_PHASES   (NUM_PHASES)
    ) u_durBank (
        .i_CLK      (i_CLK),
        .i_RST      (i_RST),
        .i_LOAD     (w_load),
        .i_DUR      (i_DUR),
        .i_CUR_SEL  (r_phase),
        .i_PEEK_SEL (w_nextPhase),
        .o_CUR_DUR  (w_curDur),
        .o_PEEK_DUR (w_peekDur)
    );

    // State, phase index and the registered pulse outputs.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            r_state  <= IDLE;
            r_phase  <= '0;
            r_cntRst <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_nextState;
            r_phase  <= w_nextPhase;
            r_cntRst <= w_cntRstNext;
            r_done   <= w_doneNext;
        end
    end

    // Next-state and next-phase decode; abort overrides every other input.
    always_comb begin
        w_nextState = r_state;
        w_nextPhase = r_phase;
        w_load      = 1'b0;
        if (i_ABORT) begin
            w_nextState = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_START) begin
                        w_nextState = ARM;
                        w_nextPhase = '0;
                        w_load      = 1'b1;
                    end
                end
                ARM: begin
                    w_nextState = (w_curDur == '0) ? ADVANCE : WAIT;
                end
                WAIT: begin
                    if (i_OVERFLOW) begin
                        w_nextState = ADVANCE;
                    end
                end
                ADVANCE: begin
                    if (r_phase < LAST_PHASE) begin
                        w_nextPhase = r_phase + PW'(1);
                        w_nextState = ARM;
                    end else begin
`ifdef PHASE_SEQ_LOOP_EN
                        w_nextPhase = '0;
                        w_nextState = ARM;
`else
                        w_nextState = DONE;
`endif
                    end
                end
                DONE: begin
                    w_nextState = IDLE;
                end
                default: begin
                    w_nextState = IDLE;
                end
            endcase
        end
    end

    // The counter restart is raised for the cycle spent in ARM, but only
    // when the phase being armed has a non-zero duration; an abort out of
    // any active state also restarts the counter so it is left clean.
    assign w_cntRstNext = (i_ABORT && (r_state != IDLE)) ||
                          ((w_nextState == ARM) && (w_peekDur != '0));
    assign w_doneNext   = (w_nextState == DONE);

    assign o_LIM     = w_curDur;
    assign o_CNT_RST = r_cntRst;
    assign o_PHASE   = r_phase;
    assign o_BUSY    = (r_state != IDLE);
    assign o_DONE    = r_done;

endmodule

// File: tb/tb_phase_sequencer.sv
// Testbench for phase_sequencer. A behavioural limit counter closes the
// loop; counter-restart and done pulses are predicted from the phase
// durations with plain arithmetic and checked through a scoreboard queue,
// while phase/busy/limit are compared every cycle against the same model.
// Honours PHASE_SEQ_LOOP_EN when the design is built with it.
module tb_phase_sequencer;

    localparam int CB = 32;
    localparam int NP = 4;
    localparam int PW = 2;
`ifdef PHASE_SEQ_LOOP_EN
    localparam bit LOOP_MODE = 1'b1;
`else
    localparam bit LOOP_MODE = 1'b0;
`endif

    logic            clk;
    logic            rst;
    logic            start;
    logic            abort;
    logic            overflow;
    logic            cntRst;
    logic            busy;
    logic            done;
    logic [NP*CB-1:0] dur;
    logic [CB-1:0]   lim;
    logic [CB-1:0]   limCount;
    logic [PW-1:0]   phase;

    typedef struct {
        bit     isDone;
        int     ph;
        longint lim;
        bit     busy;
        int     expEdge;
    } evt_t;

    evt_t expQ[$];
    int   checks    = 0;
    int   errors    = 0;
    int   edgeCount = 0;
    int   passDur [NP];
    int   phStart [NP];
    int   passLen;

    phase_sequencer #(
        .COUNTER_BITS (CB),
        .NUM_PHASES   (NP)
    ) dut (
        .i_CLK      (clk),
        .i_RST      (rst),
        .i_START    (start),
        .i_ABORT    (abort),
        .i_DUR      (dur),
        .i_OVERFLOW (overflow),
        .o_LIM      (lim),
        .o_CNT_RST  (cntRst),
        .o_PHASE    (phase),
        .o_BUSY     (busy),
        .o_DONE     (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) edgeCount++;

    // Behavioural downstream counter: clears on restart, counts up to the limit.
    always @(posedge clk or posedge rst) begin
        if (rst) limCount <= '0;
        else if (cntRst) limCount <= '0;
        else if (limCount < lim) limCount <= limCount + 1;
    end
    assign overflow = (limCount >= lim);

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d required=%0d (edge %0d)", name, act, exp, edgeCount);
        end
    endtask

    function automatic void pushEvt(input bit isDone, input int ph, input bit b, input int e);
        evt_t ev;
        ev.isDone  = isDone;
        ev.ph      = ph;
        ev.lim     = passDur[ph];
        ev.busy    = b;
        ev.expEdge = e;
        expQ.push_back(ev);
    endfunction

    // Phase p occupies ARM + (d+1) WAIT + ADVANCE cycles, or ARM + ADVANCE if d is 0.
    function automatic void computeSchedule();
        int acc;
        acc = 0;
        for (int p = 0; p < NP; p++) begin
            phStart[p] = acc;
            acc += (passDur[p] == 0) ? 2 : passDur[p] + 3;
        end
        passLen = acc;
    endfunction

    function automatic int phaseAt(input int o);
        int r;
        int ph;
        r = o;
        if (LOOP_MODE) r = o % passLen;
        else if (o >= passLen) return NP - 1;
        ph = 0;
        for (int p = 0; p < NP; p++) if (phStart[p] <= r) ph = p;
        return ph;
    endfunction

    function automatic void setDur(input int d0, input int d1, input int d2, input int d3);
        passDur[0] = d0;
        passDur[1] = d1;
        passDur[2] = d2;
        passDur[3] = d3;
    endfunction

    // Scoreboard monitor: every restart or done pulse must match the next prediction.
    always @(negedge clk) begin
        evt_t e;
        if (!rst && (cntRst === 1'b1 || done === 1'b1)) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpectedPulse actual cntRst=%0b done=%0b phase=%0d edge=%0d required no pulse",
                         cntRst, done, phase, edgeCount);
            end else begin
                e = expQ.pop_front();
                checkOutput("pulseDone",   done,      e.isDone);
                checkOutput("pulseCntRst", cntRst,    !e.isDone);
                checkOutput("pulsePhase",  phase,     e.ph);
                checkOutput("pulseLim",    lim,       e.lim);
                checkOutput("pulseBusy",   busy,      e.busy);
                checkOutput("pulseEdge",   edgeCount, e.expEdge);
            end
        end
    end

    // Runs one start from IDLE using passDur; abortOff/rstOff pick the cycle
    // (offset from the first ARM cycle) for an abort or reset, -1 for none.
    task automatic applyStimulus(input int abortOff, input int rstOff,
                                 input int scrambleOff, input bit scrambleOnes);
        int A;
        int cutoff;
        int off;
        int ref_;
        bit useAbort;
        bit useRst;
        computeSchedule();
        useAbort = (abortOff >= 0);
        useRst   = !useAbort && (rstOff >= 0);
        if (useAbort) cutoff = abortOff;
        else if (useRst) cutoff = rstOff;
        else if (LOOP_MODE) begin
            useAbort = 1'b1;
            cutoff   = 3 * passLen + $urandom_range(passLen - 1);
        end else cutoff = passLen;

        A = edgeCount + 1;
        for (int k = 0; k * passLen <= cutoff; k++) begin
            for (int p = 0; p < NP; p++) begin
                off = k * passLen + phStart[p];
                if (passDur[p] != 0 && off <= cutoff) pushEvt(1'b0, p, 1'b1, A + off);
            end
            if (!LOOP_MODE) break;
        end
        if (!LOOP_MODE && passLen <= cutoff) pushEvt(1'b1, NP - 1, 1'b1, A + passLen);
        if (useAbort) pushEvt(1'b0, phaseAt(cutoff), 1'b0, A + cutoff + 1);

        for (int p = 0; p < NP; p++) dur[p*CB +: CB] = CB'(passDur[p]);
        start = 1'b1;
        abort = 1'b0;
        for (int o = 0; o <= cutoff + 3; o++) begin
            @(negedge clk);
            start = (o <= cutoff) ? 1'($urandom_range(1)) : 1'b0;
            abort = useAbort && (o == cutoff);
            if (scrambleOff >= 0 && o >= scrambleOff) begin
                if (scrambleOnes) begin
                    for (int p = 0; p < NP; p++) dur[p*CB +: CB] = CB'(1);
                end else begin
                    for (int p = 0; p < NP; p++) dur[p*CB +: CB] = $urandom;
                end
            end
            ref_ = phaseAt((o < cutoff) ? o : cutoff);
            checkOutput("phase", phase, ref_);
            checkOutput("busy",  busy,  (o <= cutoff) ? 1 : 0);
            checkOutput("lim",   lim,   passDur[ref_]);
            if (useRst && o == cutoff) begin
                start = 1'b0;
                #2 rst = 1'b1;
                #1;
                checkOutput("rstPhase",  phase,  0);
                checkOutput("rstLim",    lim,    0);
                checkOutput("rstCntRst", cntRst, 0);
                checkOutput("rstBusy",   busy,   0);
                checkOutput("rstDone",   done,   0);
                @(negedge clk);
                rst = 1'b0;
                break;
            end
        end
        start = 1'b0;
        abort = 1'b0;
        checkOutput("queueDrained", expQ.size(), 0);
        expQ.delete();
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int sel;
        int aOff;
        int rOff;
        int sOff;
        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        dur   = '0;
        @(negedge clk);
        checkOutput("resetPhase",  phase,  0);
        checkOutput("resetLim",    lim,    0);
        checkOutput("resetCntRst", cntRst, 0);
        checkOutput("resetBusy",   busy,   0);
        checkOutput("resetDone",   done,   0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        setDur(3, 5, 2, 4);
        applyStimulus(-1, -1, -1, 1'b0);
        setDur(3, 0, 2, 4);
        applyStimulus(-1, -1, -1, 1'b0);
        setDur(3, 5, 2, 4);
        applyStimulus(16, -1, -1, 1'b0);
        applyStimulus(-1, 9, -1, 1'b0);

        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        checkOutput("startAbortBusy",   busy,   0);
        checkOutput("startAbortCntRst", cntRst, 0);
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        checkOutput("startAbortIdle", busy, 0);

        setDur(3, 5, 2, 4);
        applyStimulus(-1, -1, 7, 1'b1);
        setDur(2, 2, 2, 2);
        applyStimulus(-1, -1, -1, 1'b0);

        for (int t = 0; t < 20; t++) begin
            for (int p = 0; p < NP; p++) passDur[p] = ($urandom_range(3) == 0) ? 0 : $urandom_range(1, 6);
            computeSchedule();
            sel  = $urandom_range(7);
            aOff = (sel < 2) ? $urandom_range(passLen) : -1;
            rOff = (sel == 2) ? $urandom_range(passLen) : -1;
            sOff = ($urandom_range(1) == 1) ? $urandom_range(passLen) : -1;
            applyStimulus(aOff, rOff, sOff, 1'b0);
            repeat ($urandom_range(2)) @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
